// File: rtl/logic_avalon_mm_pkg.sv
// Shared types for the Avalon-MM pipeline bridge.
package logic_avalon_mm_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY        = 2'b00,
        RESP_RESERVED    = 2'b01,
        RESP_SLVERR      = 2'b10,
        RESP_DECODEERROR = 2'b11
    } response_t;

endpackage

// File: rtl/logic_avalon_mm_bridge_buffer.sv
// Generic 2-entry registered FIFO; full_q is a flop so it can feed a stall
// output without a combinational path from the push side.
module logic_avalon_mm_bridge_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full_q,
    output logic             empty
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  full_d;
    logic                  push_ok, pop_ok;

    always_comb begin
        push_ok  = push & !full_q;
        pop_ok   = pop & (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) rd_ptr_d = ~rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == 2'd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/logic_avalon_mm_bridge.sv
// Avalon-MM pipeline bridge: buffered command path, one-stage response path,
// and credit counters capping in-flight read beats and write responses.
module logic_avalon_mm_bridge
    import logic_avalon_mm_pkg::*;
#(
    parameter int DATA_BYTES         = 4,
    parameter int ADDRESS_WIDTH      = 32,
    parameter int BURSTCOUNT_WIDTH   = 4,
    parameter int MAX_PENDING_READS  = 16,
    parameter int MAX_PENDING_WRITES = 4,
    parameter int USE_WRITE_RESPONSE = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        s_read,
    input  logic                        s_write,
    input  logic [ADDRESS_WIDTH-1:0]    s_address,
    input  logic [DATA_BYTES*8-1:0]     s_writedata,
    input  logic [DATA_BYTES-1:0]       s_byteenable,
    input  logic [BURSTCOUNT_WIDTH-1:0] s_burstcount,
    output logic                        s_waitrequest,
    output logic [DATA_BYTES*8-1:0]     s_readdata,
    output logic                        s_readdatavalid,
    output logic                        s_writeresponsevalid,
    output response_t                   s_response,
    output logic                        m_read,
    output logic                        m_write,
    output logic [ADDRESS_WIDTH-1:0]    m_address,
    output logic [DATA_BYTES*8-1:0]     m_writedata,
    output logic [DATA_BYTES-1:0]       m_byteenable,
    output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
    input  logic                        m_waitrequest,
    input  logic [DATA_BYTES*8-1:0]     m_readdata,
    input  logic                        m_readdatavalid,
    input  logic                        m_writeresponsevalid,
    input  response_t                   m_response
);

    localparam int DW     = DATA_BYTES * 8;
    localparam int RDW    = $clog2(MAX_PENDING_READS + 2**BURSTCOUNT_WIDTH + 1);
    localparam int WRW    = $clog2(MAX_PENDING_WRITES + 2);
    localparam bit USE_WR = (USE_WRITE_RESPONSE != 0);

    typedef struct packed {
        logic                        read;
        logic                        write;
        logic [ADDRESS_WIDTH-1:0]    address;
        logic [DW-1:0]               writedata;
        logic [DATA_BYTES-1:0]       byteenable;
        logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    } cmd_t;

    cmd_t                        push_cmd, head_cmd;
    logic                        buf_full_q, buf_empty;
    logic                        accept, first_beat, read_block, write_block;
    logic                        rd_inc, wr_inc, wr_dec, rd_underflow, wr_underflow;
    logic [RDW-1:0]              rd_pending_q, rd_pending_d, rd_sum;
    logic [WRW-1:0]              wr_pending_q, wr_pending_d, wr_sum;
    logic [BURSTCOUNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]               s_readdata_q, s_readdata_d;
    logic                        s_readdatavalid_q, s_readdatavalid_d;
    logic                        s_writeresponsevalid_q, s_writeresponsevalid_d;
    response_t                   s_response_q, s_response_d;

    // Only the first beat of a write burst consumes a write credit.
    assign first_beat    = (beat_cnt_q == '0);
    assign read_block    = s_read & ((rd_pending_q + RDW'(s_burstcount)) > RDW'(MAX_PENDING_READS));
    assign write_block   = s_write & first_beat & USE_WR & (wr_pending_q == WRW'(MAX_PENDING_WRITES));
    assign s_waitrequest = buf_full_q | read_block | write_block;
    assign accept        = (s_read | s_write) & !s_waitrequest;

    // A read+write collision is forwarded as a write.
    always_comb begin
        push_cmd.read       = s_read & !s_write;
        push_cmd.write      = s_write;
        push_cmd.address    = s_address;
        push_cmd.writedata  = s_writedata;
        push_cmd.byteenable = s_byteenable;
        push_cmd.burstcount = s_burstcount;
    end

    always_comb begin
        rd_inc       = accept & s_read & !s_write;
        wr_inc       = accept & s_write & first_beat & USE_WR;
        wr_dec       = m_writeresponsevalid & USE_WR;
        rd_sum       = rd_pending_q + (rd_inc ? RDW'(s_burstcount) : RDW'(0));
        wr_sum       = wr_pending_q + WRW'(wr_inc);
        rd_underflow = m_readdatavalid & (rd_sum == '0);
        wr_underflow = wr_dec & (wr_sum == '0);
        rd_pending_d = rd_sum;
        wr_pending_d = wr_sum;
        if (m_readdatavalid && !rd_underflow) rd_pending_d = rd_sum - RDW'(1);
        if (wr_dec && !wr_underflow)          wr_pending_d = wr_sum - WRW'(1);

        beat_cnt_d = beat_cnt_q;
        if (accept && s_write) begin
            if (!first_beat)                beat_cnt_d = beat_cnt_q - 1'b1;
            else if (s_burstcount != '0)    beat_cnt_d = s_burstcount - 1'b1;
        end

        s_readdata_d           = m_readdata;
        s_readdatavalid_d      = m_readdatavalid;
        s_writeresponsevalid_d = m_writeresponsevalid & USE_WR;
        s_response_d           = m_response;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_q           <= '0;
            wr_pending_q           <= '0;
            beat_cnt_q             <= '0;
            s_readdata_q           <= '0;
            s_readdatavalid_q      <= 1'b0;
            s_writeresponsevalid_q <= 1'b0;
            s_response_q           <= RESP_OKAY;
        end else begin
            rd_pending_q           <= rd_pending_d;
            wr_pending_q           <= wr_pending_d;
            beat_cnt_q             <= beat_cnt_d;
            s_readdata_q           <= s_readdata_d;
            s_readdatavalid_q      <= s_readdatavalid_d;
            s_writeresponsevalid_q <= s_writeresponsevalid_d;
            s_response_q           <= s_response_d;
        end
    end

    logic_avalon_mm_bridge_buffer #(.WIDTH($bits(cmd_t))) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .din     (push_cmd),
        .pop     (!m_waitrequest),
        .dout    (head_cmd),
        .full_q  (buf_full_q),
        .empty   (buf_empty)
    );

    assign m_read               = !buf_empty & head_cmd.read;
    assign m_write              = !buf_empty & head_cmd.write;
    assign m_address            = head_cmd.address;
    assign m_writedata          = head_cmd.writedata;
    assign m_byteenable         = head_cmd.byteenable;
    assign m_burstcount         = head_cmd.burstcount;
    assign s_readdata           = s_readdata_q;
    assign s_readdatavalid      = s_readdatavalid_q;
    assign s_writeresponsevalid = s_writeresponsevalid_q;
    assign s_response           = s_response_q;

`ifndef SYNTHESIS
    // Responses arriving before any new command are stragglers from before a
    // reset; they legitimately hit an empty counter and are not flagged.
    logic cmd_seen_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    cmd_seen_q <= 1'b0;
        else if (accept) cmd_seen_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(s_read && s_write)) else $error("s_read and s_write both asserted");
            assert (!(cmd_seen_q && (rd_underflow || wr_underflow))) else $error("credit counter underflow");
        end
    end
`endif

endmodule

// File: tb/tb_logic_avalon_mm_bridge.sv
// Directed bench: instance A uses default widths/credits, instance B a
// 4-beat read window with write-credit gating disabled.
module tb_logic_avalon_mm_bridge;
    import logic_avalon_mm_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic a_read, a_write, a_wait, a_rdv, a_wrv;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0] a_be, a_bc;
    response_t a_resp;
    logic am_read, am_write, am_wait, am_rdv, am_wrv;
    logic [31:0] am_addr, am_wdata, am_rdata;
    logic [3:0] am_be, am_bc;
    response_t am_resp;

    logic b_read, b_write, b_wait, b_rdv, b_wrv;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0] b_be;
    logic [2:0] b_bc;
    response_t b_resp;
    logic bm_read, bm_write, bm_wait, bm_rdv, bm_wrv;
    logic [31:0] bm_addr, bm_wdata, bm_rdata;
    logic [3:0] bm_be;
    logic [2:0] bm_bc;
    response_t bm_resp;

    int n_cmp = 0;
    int n_bad = 0;

    logic_avalon_mm_bridge #(
        .DATA_BYTES(4), .ADDRESS_WIDTH(32), .BURSTCOUNT_WIDTH(4),
        .MAX_PENDING_READS(16), .MAX_PENDING_WRITES(4), .USE_WRITE_RESPONSE(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .s_read(a_read), .s_write(a_write), .s_address(a_addr), .s_writedata(a_wdata),
        .s_byteenable(a_be), .s_burstcount(a_bc), .s_waitrequest(a_wait),
        .s_readdata(a_rdata), .s_readdatavalid(a_rdv), .s_writeresponsevalid(a_wrv),
        .s_response(a_resp),
        .m_read(am_read), .m_write(am_write), .m_address(am_addr), .m_writedata(am_wdata),
        .m_byteenable(am_be), .m_burstcount(am_bc), .m_waitrequest(am_wait),
        .m_readdata(am_rdata), .m_readdatavalid(am_rdv), .m_writeresponsevalid(am_wrv),
        .m_response(am_resp)
    );

    logic_avalon_mm_bridge #(
        .DATA_BYTES(4), .ADDRESS_WIDTH(32), .BURSTCOUNT_WIDTH(3),
        .MAX_PENDING_READS(4), .MAX_PENDING_WRITES(4), .USE_WRITE_RESPONSE(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .s_read(b_read), .s_write(b_write), .s_address(b_addr), .s_writedata(b_wdata),
        .s_byteenable(b_be), .s_burstcount(b_bc), .s_waitrequest(b_wait),
        .s_readdata(b_rdata), .s_readdatavalid(b_rdv), .s_writeresponsevalid(b_wrv),
        .s_response(b_resp),
        .m_read(bm_read), .m_write(bm_write), .m_address(bm_addr), .m_writedata(bm_wdata),
        .m_byteenable(bm_be), .m_burstcount(bm_bc), .m_waitrequest(bm_wait),
        .m_readdata(bm_rdata), .m_readdatavalid(bm_rdv), .m_writeresponsevalid(bm_wrv),
        .m_response(bm_resp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0; a_bc = 0;
        am_wait = 0; am_rdata = 0; am_rdv = 0; am_wrv = 0; am_resp = RESP_OKAY;
        b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_bc = 0;
        bm_wait = 0; bm_rdata = 0; bm_rdv = 0; bm_wrv = 0; bm_resp = RESP_OKAY;

        // reset state
        #12;
        chk("rst_am_read", am_read, 0);
        chk("rst_am_write", am_write, 0);
        chk("rst_a_wait", a_wait, 0);
        chk("rst_a_rdv", a_rdv, 0);
        chk("rst_a_wrv", a_wrv, 0);
        chk("rst_a_resp", a_resp, RESP_OKAY);
        chk("rst_bm_write", bm_write, 0);
        reset_n = 1'b1;
        cyc();

        // single write, one-cycle command latency
        a_write = 1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF; a_be = 4'hF; a_bc = 4'd1;
        #1;
        chk("t1_wait", a_wait, 0);
        chk("t1_mwrite_pre", am_write, 0);
        cyc(); a_write = 0; #1;
        chk("t1_mwrite", am_write, 1);
        chk("t1_maddr", am_addr, 32'h10);
        chk("t1_mdata", am_wdata, 32'hDEADBEEF);
        chk("t1_mbe", am_be, 4'hF);
        chk("t1_mbc", am_bc, 1);
        chk("t1_wait2", a_wait, 0);
        cyc(); #1;
        chk("t1_mwrite_post", am_write, 0);
        am_wrv = 1; am_resp = RESP_SLVERR;
        cyc(); am_wrv = 0; am_resp = RESP_OKAY; #1;
        chk("t1_wrv", a_wrv, 1);
        chk("t1_resp", a_resp, RESP_SLVERR);
        cyc(); #1;
        chk("t1_wrv_off", a_wrv, 0);
        chk("t1_resp_off", a_resp, RESP_OKAY);

        // three writes under downstream stall
        am_wait = 1;
        a_write = 1; a_addr = 32'h100; a_wdata = 32'd1; a_bc = 4'd1; #1;
        chk("t3_wait0", a_wait, 0);
        cyc(); a_addr = 32'h104; a_wdata = 32'd2; #1;
        chk("t3_wait1", a_wait, 0);
        chk("t3_head0_w", am_write, 1);
        chk("t3_head0_a", am_addr, 32'h100);
        cyc(); a_addr = 32'h108; a_wdata = 32'd3; #1;
        chk("t3_full", a_wait, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("t3_stall", a_wait, 1);
        end
        cyc(); am_wait = 0; #1;
        chk("t3_stall_last", a_wait, 1);
        chk("t3_head_w0", am_addr, 32'h100);
        cyc(); #1;
        chk("t3_unstall", a_wait, 0);
        chk("t3_head_w1", am_addr, 32'h104);
        chk("t3_data_w1", am_wdata, 32'd2);
        cyc(); a_write = 0; #1;
        chk("t3_head_w2", am_addr, 32'h108);
        chk("t3_data_w2", am_wdata, 32'd3);
        chk("t3_w2_valid", am_write, 1);
        cyc(); #1;
        chk("t3_drained", am_write, 0);

        // 8-beat write burst with one write credit left
        a_write = 1; a_addr = 32'h200; a_bc = 4'd8; a_wdata = 32'hB0; #1;
        chk("t4_first", a_wait, 0);
        for (int i = 1; i < 8; i++) begin
            cyc(); a_wdata = 32'hB0 + i; #1;
            chk("t4_beat_wait", a_wait, 0);
            chk("t4_beat_data", am_wdata, 32'hB0 + i - 1);
        end
        cyc(); a_addr = 32'h300; a_bc = 4'd1; a_wdata = 32'hC0; #1;
        chk("t4_credit_stall", a_wait, 1);
        chk("t4_last_beat", am_wdata, 32'hB7);
        cyc(); #1;
        chk("t4_stall2", a_wait, 1);
        chk("t4_empty", am_write, 0);
        cyc(); am_wrv = 1; #1;
        chk("t4_stall3", a_wait, 1);
        cyc(); am_wrv = 0; #1;
        chk("t4_release", a_wait, 0);
        chk("t4_wrv", a_wrv, 1);
        cyc(); a_write = 0; am_wrv = 1; #1;
        chk("t4_next_w", am_write, 1);
        chk("t4_next_a", am_addr, 32'h300);
        cyc(); am_wrv = 0;

        // reset with two buffered commands and 3 read beats pending
        am_wait = 1;
        a_read = 1; a_addr = 32'h400; a_bc = 4'd3; #1;
        chk("t6_rd_acc", a_wait, 0);
        cyc(); a_read = 0; a_write = 1; a_addr = 32'h500; a_bc = 4'd1; a_wdata = 32'h55; #1;
        chk("t6_wr_acc", a_wait, 0);
        chk("t6_head_rd", am_read, 1);
        chk("t6_head_addr", am_addr, 32'h400);
        cyc(); a_write = 0; #1;
        chk("t6_full", a_wait, 1);
        #2; reset_n = 1'b0; #1;
        chk("t6_async_read", am_read, 0);
        chk("t6_async_write", am_write, 0);
        chk("t6_async_wait", a_wait, 0);
        #2; reset_n = 1'b1; am_wait = 0;
        cyc(); am_rdv = 1; am_rdata = 32'h77;
        cyc(); am_rdv = 0; am_rdata = 0;
        a_read = 1; a_addr = 32'h600; a_bc = 4'd14; #1;
        chk("t6_stray_rdv", a_rdv, 1);
        chk("t6_stray_data", a_rdata, 32'h77);
        chk("t6_rd_cleared", a_wait, 0);
        cyc(); a_read = 0; a_write = 1; a_addr = 32'h700; a_bc = 4'd1; #1;
        chk("t6_wr_cleared", a_wait, 0);
        chk("t6_rdv_off", a_rdv, 0);
        cyc(); a_write = 0;

        // read credit window of 4 beats on instance B
        b_read = 1; b_addr = 32'h40; b_bc = 3'd4; #1;
        chk("t2_first", b_wait, 0);
        cyc(); b_addr = 32'h50; b_bc = 3'd1; #1;
        chk("t2_block", b_wait, 1);
        chk("t2_mread", bm_read, 1);
        chk("t2_maddr", bm_addr, 32'h40);
        chk("t2_mbc", bm_bc, 4);
        cyc(); #1;
        chk("t2_block2", b_wait, 1);
        chk("t2_mread_off", bm_read, 0);
        cyc(); bm_rdv = 1; bm_rdata = 32'hA0; #1;
        chk("t2_block3", b_wait, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(); bm_rdata = 32'hA0 + i;
            if (i == 2) b_read = 0;
            #1;
            if (i == 1) chk("t2_unblock", b_wait, 0);
            if (i == 2) chk("t2_mread2", bm_read, 1);
            if (i == 2) chk("t2_maddr2", bm_addr, 32'h50);
            chk("t2_rdv", b_rdv, 1);
            chk("t2_rdata", b_rdata, 32'hA0 + i - 1);
        end
        cyc(); bm_rdv = 0; #1;
        chk("t2_rdv_last", b_rdv, 1);
        chk("t2_rdata_last", b_rdata, 32'hA4);
        cyc(); #1;
        chk("t2_rdv_off", b_rdv, 0);

        // ten writes, no responses, write credits disabled
        for (int i = 0; i < 10; i++) begin
            b_write = 1; b_addr = 32'h800 + 4 * i; b_wdata = i; b_bc = 3'd1; #1;
            chk("t5_no_stall", b_wait, 0);
            if (i > 0) chk("t5_mdata", bm_wdata, i - 1);
            cyc();
        end
        b_write = 0; #1;
        chk("t5_last_w", bm_write, 1);
        chk("t5_last_d", bm_wdata, 9);
        cyc(); #1;
        chk("t5_drained", bm_write, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
